dir_button_debounce: RTL

DIR_BUTTON_DEBOUNCE -- requirements
Module: dir_button_debounce

---
 rtl/dir_button_debounce.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dir_button_debounce.sv
// -----------------------------------------------------------------------------
// dir_button_debounce
//
// Debounces two raw direction push-buttons (UP, DOWN) and turns each accepted
// press into a one-cycle request for a downstream direction SR latch. Presses
// accepted on both channels in the same cycle are reported as a conflict
// instead, so the latch never sees S and R together. Releases are debounced
// too, but they never produce pulses.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset (priority over everything)
//   btn_up     : raw, asynchronous, bouncing UP level (1 = pressed)
//   btn_down   : raw, asynchronous, bouncing DOWN level (1 = pressed)
//   up_pulse   : one-cycle set request (S), registered
//   down_pulse : one-cycle reset request (R), registered
//   up_level   : debounced UP level, registered
//   down_level : debounced DOWN level, registered
//   conflict   : one-cycle flag, both presses accepted together, registered
//
// Parameter
//   DB_CNT     : consecutive stable cycles needed to accept a change (>= 2)
// -----------------------------------------------------------------------------
module dir_button_debounce #(
    parameter int DB_CNT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_level,
    output logic down_level,
    output logic conflict
);

    localparam int CW = $clog2(DB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Channel index 0 is UP, index 1 is DOWN.
    logic [1:0]    btn_raw_s;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    press_s;
    logic [1:0]    level_d;

    logic up_pulse_q;
    logic down_pulse_q;
    logic up_level_q;
    logic down_level_q;
    logic conflict_q;

    assign btn_raw_s = {btn_down, btn_up};

    // Two-flop synchronizers for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce FSM next-state, counter and press-event logic.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            press_s[ch] = 1'b0;
            case (state_q[ch])
                IDLE: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = PRESS_WAIT;
                        cnt_d[ch]   = '0;
                    end else begin
                        state_d[ch] = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = IDLE;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = HELD;
                        press_s[ch] = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = RELEASE_WAIT;
                        cnt_d[ch]   = '0;
                    end else begin
                        state_d[ch] = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = HELD;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = IDLE;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                default: begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = '0;
                end
            endcase
            // Level follows the state being entered so it is registered
            // alongside the state itself.
            level_d[ch] = (state_d[ch] == HELD) || (state_d[ch] == RELEASE_WAIT);
        end
    end

    // FSM state and counter registers for both channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Output registers; simultaneous presses are diverted to conflict so
    // S and R are never asserted together.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
            conflict_q   <= 1'b0;
            up_level_q   <= 1'b0;
            down_level_q <= 1'b0;
        end else begin
            up_pulse_q   <= press_s[0] & ~press_s[1];
            down_pulse_q <= press_s[1] & ~press_s[0];
            conflict_q   <= press_s[0] &  press_s[1];
            up_level_q   <= level_d[0];
            down_level_q <= level_d[1];
        end
    end

    assign up_pulse   = up_pulse_q;
    assign down_pulse = down_pulse_q;
    assign up_level   = up_level_q;
    assign down_level = down_level_q;
    assign conflict   = conflict_q;

endmodule
